// File: rtl/trig_pulse_rx.sv
// trig_pulse_rx: receives 16 asynchronous coax trigger lines, votes them into a
// single "trigger present" level, qualifies pulse width and applies dead time.
//
// Ports:
//   clk, nrst        - clock and synchronous active-low reset
//   coax_in[15:0]    - asynchronous trigger lines (high while firing)
//   vote_thresh[4:0] - minimum number of high lines (0 behaves as 1)
//   min_ticks[7:0]   - shortest accepted pulse, clk cycles
//   max_ticks[7:0]   - longest accepted pulse, clk cycles
//   holdoff_ticks    - dead time after an accepted/long pulse, units of 4 cycles
//   clear_counts     - zero all event counters
//   trig_out         - one-cycle strobe per accepted trigger
//   trig_width[7:0]  - width of the last accepted pulse
//   trig_count[31:0] - accepted triggers (wrapping)
//   err_short[15:0]  - too-short pulses (saturating)
//   err_long[15:0]   - too-long pulses (saturating)
//   busy             - FSM not in IDLE
module trig_pulse_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [15:0] coax_in,
  input  logic [4:0]  vote_thresh,
  input  logic [7:0]  min_ticks,
  input  logic [7:0]  max_ticks,
  input  logic [7:0]  holdoff_ticks,
  input  logic        clear_counts,
  output logic        trig_out,
  output logic [7:0]  trig_width,
  output logic [31:0] trig_count,
  output logic [15:0] err_short,
  output logic [15:0] err_long,
  output logic        busy
);

  localparam int unsigned LINES   = 16;
  localparam int unsigned ONES_W  = 5;
  localparam int unsigned WIDTH_W = 8;
  localparam int unsigned HOLD_W  = 10;

  typedef enum logic [1:0] {IDLE, MEASURE, WAIT_LOW, HOLDOFF} state_t;

  logic [SYNC_STAGES-1:0][LINES-1:0] sync_q;
  logic [LINES-1:0]   sync_last;
  logic [ONES_W-1:0]  ones;
  logic [ONES_W-1:0]  thresh_eff;
  logic               line_hi;
  state_t             state;
  logic [WIDTH_W-1:0] width;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               acc_ev;
  logic               short_ev;
  logic               long_ev;

  // Per-line synchronizer chains
  always_ff @(posedge clk) begin
    if (!nrst) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], coax_in};
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Popcount of the synchronized lines
  always_comb begin
    ones = '0;
    for (int i = 0; i < LINES; i++) ones = ones + ONES_W'(sync_last[i]);
  end

  assign thresh_eff = (vote_thresh == '0) ? ONES_W'(1) : vote_thresh;

  // Registered vote; a threshold above 16 can never be met
  always_ff @(posedge clk) begin
    if (!nrst) line_hi <= 1'b0;
    else       line_hi <= (ones >= thresh_eff);
  end

  // Pulse classification events while measuring
  always_comb begin
    acc_ev   = 1'b0;
    short_ev = 1'b0;
    long_ev  = 1'b0;
    if (state == MEASURE) begin
      if (line_hi) begin
        long_ev = (width >= max_ticks);
      end else if (width < min_ticks) begin
        short_ev = 1'b1;
      end else if (width > max_ticks) begin
        long_ev = 1'b1;
      end else begin
        acc_ev = 1'b1;
      end
    end
  end

  // Pulse FSM with width/holdoff counters and registered outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      width      <= '0;
      hold_cnt   <= '0;
      busy       <= 1'b0;
      trig_out   <= 1'b0;
      trig_width <= '0;
    end else begin
      trig_out <= acc_ev;
      unique case (state)
        IDLE: begin
          width <= '0;
          if (line_hi) begin
            state <= MEASURE;
            width <= WIDTH_W'(1);
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (line_hi) begin
            if (long_ev) begin
              state <= WAIT_LOW;
              width <= '0;
            end else begin
              width <= width + WIDTH_W'(1);
            end
          end else begin
            width <= '0;
            if (acc_ev) trig_width <= width;
            if (short_ev) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= HOLDOFF;
              hold_cnt <= '0;
            end
          end
        end
        WAIT_LOW: begin
          if (!line_hi) begin
            state    <= HOLDOFF;
            hold_cnt <= '0;
          end
        end
        HOLDOFF: begin
          // Exit on the cycle the count reaches holdoff_ticks*4
          if (hold_cnt == {holdoff_ticks, 2'b00}) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Event counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!nrst || clear_counts) begin
      trig_count <= '0;
      err_short  <= '0;
      err_long   <= '0;
    end else begin
      if (acc_ev) trig_count <= trig_count + 32'd1;
      if (short_ev && (err_short != 16'hFFFF)) err_short <= err_short + 16'd1;
      if (long_ev && (err_long != 16'hFFFF))   err_long  <= err_long + 16'd1;
    end
  end

endmodule

// File: tb/tb_trig_pulse_rx.sv
// tb_trig_pulse_rx: directed scenarios plus randomized pulse trains for
// trig_pulse_rx, checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_trig_pulse_rx;

  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] coax_in;
  logic [4:0]  vote_thresh;
  logic [7:0]  min_ticks, max_ticks, holdoff_ticks;
  logic        clear_counts;
  logic        trig_out;
  logic [7:0]  trig_width;
  logic [31:0] trig_count;
  logic [15:0] err_short, err_long;
  logic        busy;

  always #2.5 clk = ~clk;

  trig_pulse_rx #(.SYNC_STAGES(S)) dut (
    .clk(clk), .nrst(nrst), .coax_in(coax_in), .vote_thresh(vote_thresh),
    .min_ticks(min_ticks), .max_ticks(max_ticks), .holdoff_ticks(holdoff_ticks),
    .clear_counts(clear_counts), .trig_out(trig_out), .trig_width(trig_width),
    .trig_count(trig_count), .err_short(err_short), .err_long(err_long), .busy(busy)
  );

  int ncheck = 0;
  int nerr   = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  // vote history: h[k] = vote of the coax sample taken k+1 edges ago
  bit          h [0:S];
  int          run;      // current pulse length while measuring, 0 otherwise
  int          dead;     // remaining dead-time edges
  bit          wl;       // long pulse seen, waiting for the line to drop
  bit          lh, acc, sh, lg;
  bit          m_trig, m_busy;
  logic [7:0]  m_width;
  logic [31:0] m_count;
  logic [15:0] m_short, m_long;

  function automatic bit vote(input logic [15:0] v, input logic [4:0] t);
    int th;
    th = (t == 5'd0) ? 1 : int'(t);
    return $countones(v) >= th;
  endfunction

  always @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i <= S; i++) h[i] = 1'b0;
      run = 0; dead = 0; wl = 1'b0;
      m_trig = 1'b0; m_busy = 1'b0; m_width = '0;
      m_count = '0; m_short = '0; m_long = '0;
    end else begin
      lh = h[S];
      for (int i = S; i > 0; i--) h[i] = h[i-1];
      h[0] = vote(coax_in, vote_thresh);
      acc = 1'b0; sh = 1'b0; lg = 1'b0;
      if (dead > 0) begin
        dead--;
      end else if (wl) begin
        if (!lh) begin wl = 1'b0; dead = 4 * int'(holdoff_ticks) + 1; end
      end else if (run == 0) begin
        if (lh) run = 1;
      end else if (lh) begin
        if (run >= int'(max_ticks)) begin lg = 1'b1; wl = 1'b1; run = 0; end
        else run++;
      end else begin
        if (run < int'(min_ticks)) sh = 1'b1;
        else if (run > int'(max_ticks)) begin lg = 1'b1; dead = 4 * int'(holdoff_ticks) + 1; end
        else begin acc = 1'b1; m_width = 8'(run); dead = 4 * int'(holdoff_ticks) + 1; end
        run = 0;
      end
      m_trig = acc;
      m_busy = (run > 0) || wl || (dead > 0);
      if (clear_counts) begin
        m_count = '0; m_short = '0; m_long = '0;
      end else begin
        if (acc) m_count = m_count + 32'd1;
        if (sh && m_short != 16'hFFFF) m_short = m_short + 16'd1;
        if (lg && m_long != 16'hFFFF)  m_long  = m_long + 16'd1;
      end
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      ncheck++;
      if ({trig_out, busy, trig_width, trig_count, err_short, err_long} !==
          {m_trig, m_busy, m_width, m_count, m_short, m_long}) begin
        nerr++;
        $display("FAIL cycle t=%0t dut trig=%b busy=%b w=%0d cnt=%0d es=%0d el=%0d model trig=%b busy=%b w=%0d cnt=%0d es=%0d el=%0d",
                 $time, trig_out, busy, trig_width, trig_count, err_short, err_long,
                 m_trig, m_busy, m_width, m_count, m_short, m_long);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int ntrig, tidx, lowidx, bhi;

  task automatic expect_eq(input string name, input longint act, input longint exp);
    ncheck++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic mon_reset();
    ntrig = 0; tidx = -1; lowidx = -1; bhi = -1;
  endtask

  task automatic mon(input int i);
    if (trig_out) begin ntrig++; if (tidx < 0) tidx = i; end
    if (busy && bhi < 0) bhi = i;
    if (tidx >= 0 && !busy && lowidx < 0) lowidx = i;
  endtask

  // Up to two pulses of pattern pat, index 0 = first driven cycle
  task automatic pulses(input int s1, input int h1, input int s2, input int h2,
                        input int total, input logic [15:0] pat);
    mon_reset();
    for (int i = 0; i < total; i++) begin
      coax_in = ((i >= s1 && i < s1 + h1) || (i >= s2 && i < s2 + h2)) ? pat : 16'h0;
      @(negedge clk);
      mon(i);
    end
    coax_in = 16'h0;
  endtask

  task automatic clr();
    clear_counts = 1'b1;
    @(negedge clk);
    clear_counts = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    nrst = 1'b0; coax_in = '0; vote_thresh = 5'd16; min_ticks = 8'd4;
    max_ticks = 8'd20; holdoff_ticks = 8'd2; clear_counts = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    expect_eq("reset trig_count", trig_count, 0);
    expect_eq("reset busy", busy, 0);
    expect_eq("reset trig_width", trig_width, 0);
    expect_eq("reset err_short", err_short, 0);
    nrst = 1'b1;
    @(negedge clk);

    // Basic accepted 10-cycle pulse
    pulses(0, 10, 0, 0, 40, 16'hFFFF);
    expect_eq("basic ntrig", ntrig, 1);
    expect_eq("basic trig_width", trig_width, 10);
    expect_eq("basic trig_count", trig_count, 1);
    expect_eq("basic busy low after strobe", lowidx - tidx, 9);
    expect_eq("basic entry latency", bhi, S + 1);

    // Glitch then a good pulse
    clr();
    pulses(0, 2, 0, 0, 20, 16'hFFFF);
    expect_eq("glitch ntrig", ntrig, 0);
    expect_eq("glitch err_short", err_short, 1);
    expect_eq("glitch busy", busy, 0);
    pulses(0, 10, 0, 0, 40, 16'hFFFF);
    expect_eq("after glitch ntrig", ntrig, 1);
    expect_eq("after glitch trig_count", trig_count, 1);

    // Long pulse, then a re-high that lands partly inside dead time
    clr();
    pulses(0, 50, 52, 10, 120, 16'hFFFF);
    expect_eq("long ntrig", ntrig, 0);
    expect_eq("long err_long", err_long, 1);
    expect_eq("long tail err_short", err_short, 1);

    // Voting
    clr();
    vote_thresh = 5'd9;
    pulses(0, 10, 0, 0, 30, 16'h00FF);
    expect_eq("vote9 ntrig", ntrig, 0);
    expect_eq("vote9 busy seen", bhi, -1);
    vote_thresh = 5'd8;
    pulses(0, 10, 0, 0, 30, 16'h00FF);
    expect_eq("vote8 ntrig", ntrig, 1);
    vote_thresh = 5'd0;
    pulses(0, 10, 0, 0, 30, 16'h0010);
    expect_eq("vote0 ntrig", ntrig, 1);
    expect_eq("vote trig_count", trig_count, 2);
    vote_thresh = 5'd16;

    // Pulse during holdoff is ignored, later pulse accepted
    clr();
    holdoff_ticks = 8'd4;
    pulses(0, 10, 16, 10, 60, 16'hFFFF);
    expect_eq("holdoff ntrig", ntrig, 1);
    expect_eq("holdoff trig_count", trig_count, 1);
    pulses(0, 10, 0, 0, 40, 16'hFFFF);
    expect_eq("after holdoff trig_count", trig_count, 2);
    holdoff_ticks = 8'd2;

    // Clear on the strobe cycle
    clr();
    mon_reset();
    for (int i = 0; i < 40; i++) begin
      coax_in = (i < 10) ? 16'hFFFF : 16'h0;
      @(negedge clk);
      mon(i);
      clear_counts = trig_out;
      if (tidx >= 0 && i == tidx + 1) begin
        expect_eq("clear-after-strobe trig_count", trig_count, 0);
        expect_eq("clear-after-strobe trig_width", trig_width, 10);
      end
    end
    clear_counts = 1'b0;
    expect_eq("clear-after-strobe ntrig", ntrig, 1);

    // Clear coincident with the accepting edge wins
    mon_reset();
    for (int i = 0; i < 40; i++) begin
      coax_in = (i < 7) ? 16'hFFFF : 16'h0;
      clear_counts = (i == 9 || i == 10);
      @(negedge clk);
      mon(i);
    end
    clear_counts = 1'b0;
    expect_eq("clear-wins ntrig", ntrig, 1);
    expect_eq("clear-wins trig_count", trig_count, 0);
    expect_eq("clear-wins trig_width", trig_width, 7);

    // Reset in the middle of a measurement
    clr();
    mon_reset();
    for (int i = 0; i < 30; i++) begin
      coax_in = (i < 6) ? 16'hFFFF : 16'h0;
      nrst = (i != 6);
      @(negedge clk);
      mon(i);
    end
    nrst = 1'b1;
    expect_eq("midreset ntrig", ntrig, 0);
    expect_eq("midreset trig_count", trig_count, 0);
    expect_eq("midreset err_short", err_short, 0);
    expect_eq("midreset err_long", err_long, 0);
    expect_eq("midreset busy", busy, 0);
    pulses(0, 10, 0, 0, 40, 16'hFFFF);
    expect_eq("resume trig_count", trig_count, 1);

    // Randomized pulse trains under random configurations
    for (int seg = 0; seg < 30; seg++) begin
      int mode;
      vote_thresh   = 5'($urandom_range(0, 17));
      min_ticks     = 8'($urandom_range(0, 12));
      max_ticks     = 8'($urandom_range(0, 24));
      holdoff_ticks = 8'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 1));
      for (int p = 0; p < 8; p++) begin
        int gap, len;
        gap = int'($urandom_range(0, 20));
        len = int'($urandom_range(1, 30));
        for (int g = 0; g < gap; g++) begin
          coax_in = 16'h0;
          clear_counts = ($urandom_range(0, 40) == 0);
          @(negedge clk);
        end
        for (int k = 0; k < len; k++) begin
          coax_in = (mode == 1) ? 16'($urandom) : 16'hFFFF;
          clear_counts = ($urandom_range(0, 40) == 0);
          nrst = ($urandom_range(0, 150) != 0);
          @(negedge clk);
        end
        nrst = 1'b1;
      end
      coax_in = 16'h0;
      clear_counts = 1'b0;
      repeat (40) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", nerr, ncheck);
    $finish;
  end

endmodule

// File: doc/trig_pulse_rx.md
TRIG_PULSE_RX -- requirements
Module: trig_pulse_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth per coax line (legal range 2-4).
REQ-002 SHALL have port clk, input, 1, system clock (200 MHz, 5 ns tick).
REQ-003 SHALL have port nrst, input, 1, synchronous active-low reset.
REQ-004 SHALL have port coax_in, input, 16, asynchronous trigger lines from the trigger board, all driven high while firing.
REQ-005 SHALL have port vote_thresh, input, 5, minimum number of high lines counted as "trigger present"; 0 is treated as 1.
REQ-006 SHALL have port min_ticks, input, 8, minimum accepted pulse width in clk cycles.
REQ-007 SHALL have port max_ticks, input, 8, maximum accepted pulse width in clk cycles.
REQ-008 SHALL have port holdoff_ticks, input, 8, dead time after an accepted or long pulse, in units of 4 clk cycles.
REQ-009 SHALL have port clear_counts, input, 1, synchronous clear of all counters.
REQ-010 SHALL have port trig_out, output, 1, one-cycle strobe per accepted trigger.
REQ-011 SHALL have port trig_width, output, 8, width of the last accepted pulse.
REQ-012 SHALL have port trig_count, output, 32, accepted-trigger count.
REQ-013 SHALL have port err_short, output, 16, count of too-short pulses (glitches).
REQ-014 SHALL have port err_long, output, 16, count of too-long pulses.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL pass each coax_in bit through a SYNC_STAGES flip-flop chain; the vote SHALL use only synchronized bits.
REQ-017 SHALL compute line_hi as a register, set when popcount(synchronized bits) >= max(vote_thresh,1); vote_thresh > 16 SHALL never set line_hi.
REQ-018 SHALL implement FSM states IDLE, MEASURE, WAIT_LOW, HOLDOFF.
REQ-019 In IDLE, the width counter SHALL be 0; when line_hi=1, the FSM SHALL enter MEASURE with width=1.
REQ-020 In MEASURE with line_hi=1: if width >= max_ticks, err_long SHALL increment and the FSM SHALL enter WAIT_LOW; otherwise width SHALL increment by 1.
REQ-021 In MEASURE with line_hi=0: width < min_ticks -> err_short increments, go to IDLE; width > max_ticks -> err_long increments, go to HOLDOFF; otherwise go to HOLDOFF, trig_out=1 for exactly the next cycle, trig_width<=width, trig_count increments.
REQ-022 When min_ticks > max_ticks, REQ-020/021 SHALL be applied in the order stated; no pulse SHALL be accepted.
REQ-023 WAIT_LOW SHALL stay until line_hi=0, then enter HOLDOFF; err_long SHALL increment once per pulse.
REQ-024 HOLDOFF SHALL clear a 10-bit counter on entry, increment it each cycle, and return to IDLE on the cycle the counter equals holdoff_ticks*4 (holdoff_ticks*4+1 cycles total); line_hi SHALL be ignored in HOLDOFF.
REQ-025 Measured width SHALL equal the number of clk cycles coax_in met the vote; latency from the first voted-high sample to entering MEASURE SHALL be SYNC_STAGES+1 cycles.
REQ-026 trig_count SHALL wrap modulo 2^32; err_short and err_long SHALL saturate at 16'hFFFF.
REQ-027 clear_counts=1 SHALL zero trig_count, err_short, err_long next cycle, and SHALL win over a same-cycle increment; FSM and trig_width SHALL be unaffected.
REQ-028 trig_width SHALL hold its value until the next accepted pulse.

Reset
REQ-029 nrst=0 at a clk edge SHALL force IDLE, clear the sync chains, line_hi, and the width and holdoff counters, and set all outputs to 0.
REQ-030 Reset mid-MEASURE or mid-HOLDOFF SHALL abort with no trig_out and no counter change; operation SHALL resume from IDLE on the first edge with nrst=1.

Verification
REQ-031 coax_in=16'hFFFF for 10 cycles, vote_thresh=16, min=4, max=20, holdoff=2 -> one trig_out, trig_width=10, trig_count=1, busy low 9 cycles after trig_out.
REQ-032 coax_in=16'hFFFF for 2 cycles, min=4 -> err_short=1, no trig_out, FSM back in IDLE, next 10-cycle pulse accepted.
REQ-033 coax_in held high for 50 cycles, max=20 -> err_long=1 exactly once, no trig_out, no re-trigger until low plus 4*holdoff_ticks+1 cycles.
REQ-034 Vote: 8 lines high, vote_thresh=9 -> no activity; vote_thresh=8 -> accepted pulse; vote_thresh=0 with 1 line high -> accepted.
REQ-035 Second 10-cycle pulse starting 3 cycles after trig_out with holdoff=4 -> ignored, trig_count stays 1; same pulse after holdoff -> trig_count=2.
REQ-036 clear_counts asserted on the trig_out cycle -> all counters 0 next cycle; trig_width retained; nrst pulsed mid-MEASURE -> no strobe, counters unchanged.
